// File: rtl/wb_bfm_pkg.sv
// Shared Wishbone B4 BFM types: cycle/burst type encodings, slave FSM states
// and width helpers used by the slave memory model and the burst address generator.
package wb_bfm_pkg;

  localparam int unsigned CTI_WIDTH  = 3;
  localparam int unsigned BTE_WIDTH  = 2;
  localparam int unsigned WAIT_WIDTH = 4;

  typedef enum logic [CTI_WIDTH-1:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_e;

  typedef enum logic [BTE_WIDTH-1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } slv_state_e;

  function automatic int unsigned wb_sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/wb_slave_mem_bfm_if.sv
// Wishbone B4 registered-feedback bus bundle, plus the per-access wait-state
// control consumed by the slave memory model.
interface wb_slave_mem_bfm_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
) ();
  import wb_bfm_pkg::*;

  localparam int unsigned SEL_WIDTH = wb_sel_width(WB_DATA_WIDTH);

  logic [WB_ADDR_WIDTH-1:0] adr;
  logic [WB_DATA_WIDTH-1:0] dat_w;
  logic [WB_DATA_WIDTH-1:0] dat_r;
  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic [SEL_WIDTH-1:0]     sel;
  logic [CTI_WIDTH-1:0]     cti;
  logic [BTE_WIDTH-1:0]     bte;
  logic                     ack;
  logic                     err;
  logic [WAIT_WIDTH-1:0]    wait_cycles;

  modport master (
    output adr, dat_w, cyc, stb, we, sel, cti, bte, wait_cycles,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel, cti, bte, wait_cycles,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_burst_addr_gen.sv
// Next-beat byte address for Wishbone bursts: linear increment, or wrap inside
// an aligned 4/8/16-beat block.
module wb_burst_addr_gen
  import wb_bfm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0] cur_adr,
  input  logic [BTE_WIDTH-1:0]  bte,
  output logic [ADDR_WIDTH-1:0] nxt_adr
);

  logic [ADDR_WIDTH-1:0] inc_c;
  logic [ADDR_WIDTH-1:0] mask_c;

  // Bits under mask_c advance, bits above it stay put (all-ones mask = linear).
  always_comb begin
    inc_c = cur_adr + ADDR_WIDTH'(SEL_WIDTH);
    case (bte_e'(bte))
      WRAP4:   mask_c = ADDR_WIDTH'(4 * SEL_WIDTH - 1);
      WRAP8:   mask_c = ADDR_WIDTH'(8 * SEL_WIDTH - 1);
      WRAP16:  mask_c = ADDR_WIDTH'(16 * SEL_WIDTH - 1);
      default: mask_c = '1;
    endcase
    nxt_adr = (cur_adr & ~mask_c) | (inc_c & mask_c);
  end

endmodule

// File: rtl/wb_slave_mem_bfm.sv
// Wishbone B4 registered-feedback slave memory: programmable wait states,
// byte-select writes, incrementing/wrapping bursts and ERR for out-of-range beats.
module wb_slave_mem_bfm
  import wb_bfm_pkg::*;
#(
  parameter int unsigned             WB_ADDR_WIDTH = 32,
  parameter int unsigned             WB_DATA_WIDTH = 32,
  parameter int unsigned             MEM_DEPTH     = 1024,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input logic               clk,
  input logic               rstn,
  wb_slave_mem_bfm_if.slave wb
);

  localparam int unsigned SEL_WIDTH = wb_sel_width(WB_DATA_WIDTH);
  localparam int unsigned OFF_W     = $clog2(SEL_WIDTH);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [WB_ADDR_WIDTH:0] SPAN = (WB_ADDR_WIDTH + 1)'(MEM_DEPTH * SEL_WIDTH);

  slv_state_e               state_q, state_d;
  logic [WAIT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic [WB_DATA_WIDTH-1:0] dat_r_q, dat_r_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                     cont_q, cont_d;

  logic [WB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                     req_c;
  logic                     beat_go_c;
  logic [WB_ADDR_WIDTH-1:0] beat_adr_c;
  logic [WB_ADDR_WIDTH-1:0] beat_off_c;
  logic                     in_rng_c;
  logic [IDX_W-1:0]         idx_c;
  logic                     wr_en_c;
  logic [WB_ADDR_WIDTH-1:0] nxt_adr_c;

  assign req_c = wb.cyc & wb.stb;

  wb_burst_addr_gen #(
    .ADDR_WIDTH (WB_ADDR_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_addr_gen (
    .cur_adr (adr_q),
    .bte     (wb.bte),
    .nxt_adr (nxt_adr_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      adr_q   <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
      adr_q   <= adr_d;
      cont_q  <= cont_d;
    end
  end

  // beat_go_c marks the edge that raises ack/err and commits a write.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_r_d    = '0;
    adr_d      = adr_q;
    cont_d     = cont_q;
    beat_go_c  = 1'b0;
    beat_adr_c = wb.adr;
    wr_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (wb.wait_cycles != '0) begin
            state_d = WAIT;
            cnt_d   = wb.wait_cycles;
          end else begin
            beat_go_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == WAIT_WIDTH'(1)) begin
          beat_go_c = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      RESP, BURST: begin
        if (cont_q && req_c) begin
          beat_go_c  = 1'b1;
          beat_adr_c = nxt_adr_c;
        end else begin
          state_d = IDLE;
          cont_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cont_d  = 1'b0;
      end
    endcase

    beat_off_c = beat_adr_c - BASE_ADDR;
    in_rng_c   = {1'b0, beat_off_c} < SPAN;
    idx_c      = beat_off_c[OFF_W +: IDX_W];

    if (beat_go_c) begin
      state_d = (state_q == RESP || state_q == BURST) ? BURST : RESP;
      ack_d   = in_rng_c;
      err_d   = ~in_rng_c;
      adr_d   = beat_adr_c;
      // A burst continues only past an in-range incrementing beat.
      cont_d  = in_rng_c && (cti_e'(wb.cti) == INCR);
      wr_en_c = in_rng_c && wb.we;
      if (in_rng_c && !wb.we) begin
        dat_r_d = mem_q[idx_c];
      end
    end
  end

  // Storage is never reset, and no write lands on a reset edge.
  always_ff @(posedge clk) begin
    if (rstn && wr_en_c) begin
      for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
        if (wb.sel[b]) begin
          mem_q[idx_c][8*b +: 8] <= wb.dat_w[8*b +: 8];
        end
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_r = dat_r_q;

endmodule

// File: tb/tb_wb_slave_mem_bfm.sv
// Bench for wb_slave_mem_bfm: table of classic accesses plus hand-written burst,
// abort and reset sequences, all responses checked through a scoreboard queue.
module tb_wb_slave_mem_bfm;
  import wb_bfm_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  ws;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  wb_slave_mem_bfm_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

  wb_slave_mem_bfm #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .MEM_DEPTH     (1024),
    .BASE_ADDR     (32'h0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_err, input logic chk_dat, input logic [31:0] dat);
    exp_t e;
    e.is_err  = is_err;
    e.chk_dat = chk_dat;
    e.dat     = dat;
    sb_q.push_back(e);
  endtask

  // Every ack/err cycle consumes one scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.ack || bus.err) begin
      if (bus.ack && bus.err) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_err_exclusive: got ack=1 err=1 expected one-hot");
      end else if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", bus.ack, bus.err);
      end else begin
        e = sb_q.pop_front();
        chk("resp_err", 32'(bus.err), 32'(e.is_err));
        if (e.chk_dat) chk("resp_dat", bus.dat_r, e.dat);
      end
    end
  end

  task automatic add_vec(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [3:0] ws,
                         input logic exp_err, input logic [31:0] exp_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ws = ws;
    v.exp_err = exp_err; v.exp_dat = exp_dat;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    bus.adr = v.adr; bus.dat_w = v.dat; bus.sel = v.sel; bus.we = v.we;
    bus.cti = CLASSIC; bus.bte = LINEAR; bus.wait_cycles = v.ws;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    push_exp(v.exp_err, !v.we || v.exp_err, v.exp_dat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(bus.ack || bus.err) && lat < 40);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    chk({nm, "_lat"}, 32'(lat), 32'(v.ws) + 32'd1);
    tick();
  endtask

  task automatic read_chk(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    vec_t v;
    v.we = 1'b0; v.adr = adr; v.dat = '0; v.sel = 4'hF; v.ws = 4'd0;
    v.exp_err = 1'b0; v.exp_dat = exp;
    run_vec(v, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.adr = '0; bus.dat_w = '0; bus.sel = '0; bus.we = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.cti = CLASSIC; bus.bte = LINEAR;
    bus.wait_cycles = '0;

    // Held reset with a request pending: outputs stay quiet.
    bus.cyc = 1'b1; bus.stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_dat", bus.dat_r, 32'd0);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    rstn = 1'b1;
    tick();

    //      we    adr           dat           sel   ws  err   exp_dat
    add_vec(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b0, 32'h10,       32'h0,        4'hF, 0,  1'b0, 32'hDEADBEEF);
    add_vec(1'b1, 32'h20,       32'h11223344, 4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 0,  1'b0, 32'h0);
    add_vec(1'b0, 32'h20,       32'h0,        4'h2, 0,  1'b0, 32'h11BB33DD);
    add_vec(1'b0, 32'h13,       32'h0,        4'hF, 3,  1'b0, 32'hDEADBEEF);
    add_vec(1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h1000,     32'h12345678, 4'hF, 0,  1'b1, 32'h0);
    add_vec(1'b0, 32'h0,        32'h0,        4'hF, 0,  1'b0, 32'hCAFEF00D);
    add_vec(1'b0, 32'h1000,     32'h0,        4'hF, 0,  1'b1, 32'h0);
    add_vec(1'b1, 32'hFFC,      32'h01020304, 4'hF, 1,  1'b0, 32'h0);
    add_vec(1'b1, 32'hFFC,      32'h55AA0000, 4'hC, 2,  1'b0, 32'h0);
    add_vec(1'b0, 32'hFFC,      32'h0,        4'hF, 15, 1'b0, 32'h55AA0304);
    add_vec(1'b0, 32'hFFFFFFFC, 32'h0,        4'hF, 4,  1'b1, 32'h0);
    add_vec(1'b1, 32'h0,        32'h0,        4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h4,        32'h1,        4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h8,        32'h2,        4'hF, 1,  1'b0, 32'h0);
    add_vec(1'b1, 32'hC,        32'h3,        4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h40,       32'h0,        4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h84,       32'h0,        4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h88,       32'hFFFF0000, 4'hF, 0,  1'b0, 32'h0);
    add_vec(1'b1, 32'h80,       32'h0,        4'hF, 7,  1'b0, 32'h0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset lands on the edge that would ack a write: nothing commits.
    bus.adr = 32'h10; bus.dat_w = 32'h0BADBAD0; bus.sel = 4'hF; bus.we = 1'b1;
    bus.cti = CLASSIC; bus.wait_cycles = 4'd2; bus.cyc = 1'b1; bus.stb = 1'b1;
    tick();
    tick();
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("midrst_ack", 32'(bus.ack), 32'd0);
      chk("midrst_dat", bus.dat_r, 32'd0);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    rstn = 1'b1;
    tick();
    read_chk(32'h10, 32'hDEADBEEF, "midrst_mem");

    // Abort during wait states: cyc drops after two cycles.
    bus.adr = 32'h40; bus.dat_w = 32'h12345678; bus.sel = 4'hF; bus.we = 1'b1;
    bus.wait_cycles = 4'd5; bus.cyc = 1'b1; bus.stb = 1'b1;
    tick();
    tick();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_ack", 32'(bus.ack), 32'd0);
    end
    read_chk(32'h40, 32'h0, "abort_mem");

    // Wrap4 read from 0x08: beats return words 2,3,0,1 back to back.
    bus.adr = 32'h8; bus.we = 1'b0; bus.sel = 4'hF; bus.cti = INCR; bus.bte = WRAP4;
    bus.wait_cycles = 4'd0; bus.cyc = 1'b1; bus.stb = 1'b1;
    push_exp(1'b0, 1'b1, 32'd2);
    push_exp(1'b0, 1'b1, 32'd3);
    push_exp(1'b0, 1'b1, 32'd0);
    push_exp(1'b0, 1'b1, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap4_ack%0d", i), 32'(bus.ack), 32'd1);
      if (i == 2) bus.cti = EOB;
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.cti = CLASSIC; bus.bte = LINEAR;
    tick();
    chk("wrap4_end", 32'(bus.ack), 32'd0);

    // Linear write burst running off the top of memory: err on the third beat.
    bus.adr = 32'hFF8; bus.dat_w = 32'h11; bus.we = 1'b1; bus.sel = 4'hF;
    bus.cti = INCR; bus.bte = LINEAR; bus.cyc = 1'b1; bus.stb = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b1, 1'b1, 32'h0);
    tick();
    bus.dat_w = 32'h22;
    tick();
    bus.dat_w = 32'h33;
    tick();
    chk("cross_err", 32'(bus.err), 32'd1);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = CLASSIC;
    tick();
    chk("cross_end", 32'(bus.err), 32'd0);
    read_chk(32'hFF8, 32'h11, "cross_mem0");
    read_chk(32'hFFC, 32'h22, "cross_mem1");

    // stb drops mid-burst: the pending beat is neither acked nor written.
    bus.adr = 32'h80; bus.dat_w = 32'hA0; bus.we = 1'b1; bus.sel = 4'hF;
    bus.cti = INCR; bus.bte = LINEAR; bus.cyc = 1'b1; bus.stb = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0);
    push_exp(1'b0, 1'b0, 32'h0);
    tick();
    bus.dat_w = 32'hA1;
    tick();
    bus.stb = 1'b0; bus.dat_w = 32'hA2;
    tick();
    chk("stbdrop_ack", 32'(bus.ack), 32'd0);
    bus.cyc = 1'b0; bus.we = 1'b0; bus.cti = CLASSIC;
    tick();
    read_chk(32'h80, 32'hA0, "stbdrop_mem0");
    read_chk(32'h84, 32'hA1, "stbdrop_mem1");
    read_chk(32'h88, 32'hFFFF0000, "stbdrop_mem2");

    tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
